// File: rtl/grid_cursor_ctrl.sv
// Cursor/piece position controller: synchronised key presses applied once per frame with clamping and gravity.
// Optional held-key auto-repeat for left/right/down is enabled by defining KEY_REPEAT_EN.
module grid_cursor_ctrl #(
  parameter int GRID_W         = 8,
  parameter int GRID_H         = 18,
  parameter int COORD_W        = 8,
  parameter int SPAWN_X        = 3,
  parameter int GRAVITY_FRAMES = 30,
  parameter int REPEAT_DELAY   = 12,
  parameter int REPEAT_RATE    = 4
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic [3:0]         op_keys,
  input  logic               draw_finish,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  output logic               coord_value,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               landed
);

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] X_SPAWN = COORD_W'(SPAWN_X);
  localparam int FCNT_W  = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
  localparam int GF_LAST = (GRAVITY_FRAMES > 0) ? GRAVITY_FRAMES - 1 : 0;

  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;

  logic [3:0]        key_s1, key_s2, key_prev;
  logic              df_s1, df_s2, df_prev;
  logic [3:0]        key_rise;
  logic              frame_tick;
  logic [3:0]        pend;
  logic [3:0]        rep_set;
  logic [FCNT_W-1:0] fcnt;
  logic              grav_due;
  logic              land;
  logic              want_up, want_dn;
  logic [COORD_W-1:0] nx, ny;

  assign key_rise   = key_s2 & ~key_prev;
  assign frame_tick = df_s2 & ~df_prev;
  assign grav_due   = (GRAVITY_FRAMES > 0) && (fcnt == FCNT_W'(GF_LAST));

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_prev <= '0;
      df_s1    <= 1'b0;
      df_s2    <= 1'b0;
      df_prev  <= 1'b0;
    end else begin
      key_s1   <= op_keys;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      df_s1    <= draw_finish;
      df_s2    <= df_s1;
      df_prev  <= df_s2;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  logic [RPT_W-1:0] hold_cnt [1:3];
  logic [RPT_W-1:0] hold_nxt [1:3];

  // Counter stops at DELAY+RATE and folds back to DELAY so it never overflows.
  always_comb begin
    rep_set = '0;
    for (int k = 1; k <= 3; k++) begin
      hold_nxt[k] = hold_cnt[k] + 1'b1;
      if (hold_nxt[k] == RPT_W'(REPEAT_DELAY)) begin
        rep_set[k] = key_s2[k];
      end else if (hold_nxt[k] == RPT_W'(REPEAT_DELAY + REPEAT_RATE)) begin
        rep_set[k]  = key_s2[k];
        hold_nxt[k] = RPT_W'(REPEAT_DELAY);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= 3; k++) hold_cnt[k] <= '0;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        if (!key_s2[k]) begin
          hold_cnt[k] <= '0;
        end else if (frame_tick) begin
          hold_cnt[k] <= hold_nxt[k];
        end
      end
    end
  end
`else
  assign rep_set = '0;
`endif

  always_comb begin
    want_up = pend[K_UP];
    want_dn = pend[K_DOWN] | grav_due;
    land    = grav_due && (cur_y == Y_MAX) && !pend[K_UP];
    nx      = cur_x;
    ny      = cur_y;
    if (land) begin
      nx = X_SPAWN;
      ny = '0;
    end else begin
      if (pend[K_LEFT] && !pend[K_RIGHT] && cur_x != '0) begin
        nx = cur_x - 1'b1;
      end else if (pend[K_RIGHT] && !pend[K_LEFT] && cur_x != X_MAX) begin
        nx = cur_x + 1'b1;
      end
      if (want_up && !want_dn && cur_y != '0) begin
        ny = cur_y - 1'b1;
      end else if (want_dn && !want_up && cur_y != Y_MAX) begin
        ny = cur_y + 1'b1;
      end
    end
  end

  // A press detected on the tick cycle survives the clear and lands on the next frame.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      fcnt        <= '0;
      cur_x       <= X_SPAWN;
      cur_y       <= '0;
      landed      <= 1'b0;
      coord_value <= 1'b0;
    end else begin
      coord_value <= (x_coord == cur_x) && (y_coord == cur_y);
      if (frame_tick) begin
        cur_x  <= nx;
        cur_y  <= ny;
        landed <= land;
        pend   <= key_rise | rep_set;
        if (GRAVITY_FRAMES > 0) begin
          fcnt <= grav_due ? '0 : fcnt + 1'b1;
        end
      end else begin
        landed <= 1'b0;
        pend   <= pend | key_rise;
      end
    end
  end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed bench for grid_cursor_ctrl: one instance without gravity, one with GRAVITY_FRAMES=2.
module tb_grid_cursor_ctrl;

  logic       vga_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] op_keys = 4'b0;
  logic       draw_finish = 1'b0;
  logic [7:0] x_coord = 8'd0;
  logic [7:0] y_coord = 8'd0;

  logic       cv_n, ld_n, cv_g, ld_g;
  logic [7:0] cx_n, cy_n, cx_g, cy_g;

  int vectors = 0;
  int miscompares = 0;
  int land_cnt_g = 0;
  int exp_x;

  always #5 vga_clk = ~vga_clk;

  always @(negedge vga_clk) if (ld_g) land_cnt_g++;

  grid_cursor_ctrl #(.GRAVITY_FRAMES(0), .REPEAT_DELAY(2), .REPEAT_RATE(1)) dut_n (
    .vga_clk(vga_clk), .rst_n(rst_n), .op_keys(op_keys), .draw_finish(draw_finish),
    .x_coord(x_coord), .y_coord(y_coord), .coord_value(cv_n),
    .cur_x(cx_n), .cur_y(cy_n), .landed(ld_n));

  grid_cursor_ctrl #(.GRAVITY_FRAMES(2), .REPEAT_DELAY(2), .REPEAT_RATE(1)) dut_g (
    .vga_clk(vga_clk), .rst_n(rst_n), .op_keys(op_keys), .draw_finish(draw_finish),
    .x_coord(x_coord), .y_coord(y_coord), .coord_value(cv_g),
    .cur_x(cx_g), .cur_y(cy_g), .landed(ld_g));

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic press_key(input int k);
    op_keys[k] = 1'b1;
    wait_cycles(5);
    op_keys[k] = 1'b0;
    wait_cycles(5);
  endtask

  task automatic do_frame();
    draw_finish = 1'b1;
    wait_cycles(50);
    draw_finish = 1'b0;
    wait_cycles(10);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    vectors++;
    if (cx_n !== 8'd3 || cy_n !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_pos: got x=%0d y=%0d want x=3 y=0", cx_n, cy_n);
    end
    vectors++;
    if (cv_n !== 1'b0 || ld_n !== 1'b0 || ld_g !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got cv=%b ld=%b ldg=%b want 0 0 0", cv_n, ld_n, ld_g);
    end
    rst_n = 1'b1;
    wait_cycles(2);
    x_coord = 8'd3;
    y_coord = 8'd0;
    vectors++;
    if (cv_n !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL query_latency: got %b want 0", cv_n);
    end
    wait_cycles(1);
    vectors++;
    if (cv_n !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL query_hit: got %b want 1", cv_n);
    end
  endtask

  task automatic test_right_moves();
    int exp_r [6] = '{4, 5, 6, 7, 7, 7};
    for (int i = 0; i < 6; i++) begin
      press_key(3);
      do_frame();
      vectors++;
      if (cx_n !== 8'(exp_r[i])) begin
        miscompares++;
        $display("[TB] FAIL right_step%0d: got %0d want %0d", i, cx_n, exp_r[i]);
      end
    end
    op_keys[2] = 1'b1;
    op_keys[3] = 1'b1;
    wait_cycles(5);
    op_keys = 4'b0;
    wait_cycles(5);
    do_frame();
    vectors++;
    if (cx_n !== 8'd7) begin
      miscompares++;
      $display("[TB] FAIL left_right_cancel: got %0d want 7", cx_n);
    end
    x_coord = 8'd7;
    y_coord = 8'd0;
    wait_cycles(2);
    vectors++;
    if (cv_n !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL query_after_move: got %b want 1", cv_n);
    end
    exp_x = 7;
  endtask

  task automatic test_up_down();
    press_key(0);
    do_frame();
    vectors++;
    if (cy_n !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL up_at_top: got %0d want 0", cy_n);
    end
    do_frame();
    vectors++;
    if (cy_n !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL up_cleared: got %0d want 0", cy_n);
    end
    press_key(1);
    do_frame();
    vectors++;
    if (cy_n !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL down_step: got %0d want 1", cy_n);
    end
    op_keys[0] = 1'b1;
    op_keys[1] = 1'b1;
    wait_cycles(5);
    op_keys = 4'b0;
    wait_cycles(5);
    do_frame();
    vectors++;
    if (cy_n !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL up_down_cancel: got %0d want 1", cy_n);
    end
    press_key(0);
    do_frame();
    vectors++;
    if (cy_n !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL up_step: got %0d want 0", cy_n);
    end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_key_repeat();
    int exp_rep [6] = '{6, 6, 5, 4, 3, 2};
    op_keys[2] = 1'b1;
    wait_cycles(5);
    for (int i = 0; i < 6; i++) begin
      do_frame();
      vectors++;
      if (cx_n !== 8'(exp_rep[i])) begin
        miscompares++;
        $display("[TB] FAIL repeat_frame%0d: got %0d want %0d", i, cx_n, exp_rep[i]);
      end
    end
    op_keys[2] = 1'b0;
    wait_cycles(5);
    exp_x = 2;
  endtask
`endif

  task automatic test_left_clamp();
    for (int i = 0; i < 8; i++) begin
      press_key(2);
      do_frame();
      exp_x = (exp_x > 0) ? exp_x - 1 : 0;
      vectors++;
      if (cx_n !== 8'(exp_x)) begin
        miscompares++;
        $display("[TB] FAIL left_step%0d: got %0d want %0d", i, cx_n, exp_x);
      end
    end
  endtask

  task automatic test_gravity();
    int exp_y;
    pulse_reset();
    land_cnt_g = 0;
    for (int t = 1; t <= 35; t++) begin
      if (t == 20) press_key(3);
      do_frame();
      exp_y = (t / 2 > 17) ? 17 : t / 2;
      vectors++;
      if (cy_g !== 8'(exp_y)) begin
        miscompares++;
        $display("[TB] FAIL gravity_tick%0d: got %0d want %0d", t, cy_g, exp_y);
      end
    end
    vectors++;
    if (cx_g !== 8'd4 || land_cnt_g != 0) begin
      miscompares++;
      $display("[TB] FAIL pre_land: got x=%0d lands=%0d want x=4 lands=0", cx_g, land_cnt_g);
    end
    press_key(3);
    do_frame();
    vectors++;
    if (land_cnt_g != 1) begin
      miscompares++;
      $display("[TB] FAIL landed_pulse: got %0d cycles want 1", land_cnt_g);
    end
    vectors++;
    if (cx_g !== 8'd3 || cy_g !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL respawn: got x=%0d y=%0d want x=3 y=0", cx_g, cy_g);
    end
  endtask

  task automatic test_down_on_gravity();
    pulse_reset();
    for (int t = 1; t <= 11; t++) do_frame();
    vectors++;
    if (cy_g !== 8'd5) begin
      miscompares++;
      $display("[TB] FAIL before_down: got %0d want 5", cy_g);
    end
    press_key(1);
    do_frame();
    vectors++;
    if (cy_g !== 8'd6) begin
      miscompares++;
      $display("[TB] FAIL down_plus_gravity: got %0d want 6", cy_g);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    op_keys[3]  = 1'b1;
    draw_finish = 1'b1;
    wait_cycles(50);
    op_keys[3]  = 1'b0;
    draw_finish = 1'b0;
    wait_cycles(10);
    vectors++;
    if (cx_n !== 8'd3) begin
      miscompares++;
      $display("[TB] FAIL edge_on_tick: got %0d want 3", cx_n);
    end
    do_frame();
    vectors++;
    if (cx_n !== 8'd4) begin
      miscompares++;
      $display("[TB] FAIL edge_next_tick: got %0d want 4", cx_n);
    end
  endtask

  initial begin
    test_reset();
    test_right_moves();
    test_up_down();
`ifdef KEY_REPEAT_EN
    test_key_repeat();
`endif
    test_left_clamp();
    test_gravity();
    test_down_on_gravity();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
